// File: rtl/sdp_bram_reader.sv
// Read-side engine for a simple-dual-port BRAM: walks a contiguous address range
// and turns the one-cycle-latency read port into a valid/ready stream with a last flag.
module sdp_bram_reader #(
   parameter int DATA_W = 75,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   issue_rem, out_rem;
   logic              pending;
   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] fifo_tail;
   logic              pop, issue, load;
   logic [2:0]        occupancy;

   assign pop       = m_valid & m_ready;
   assign occupancy = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign bram_addr = rd_ptr;
   assign m_valid   = (fifo_count != 2'd0);
   assign m_last    = m_valid && (out_rem == {{ADDR_W{1'b0}}, 1'b1});

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  load      = 1'b1;
                  state_nxt = RUN;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         RUN: begin
            // Only issue when the word landing next cycle is guaranteed a FIFO slot.
            issue = (issue_rem != '0) && (occupancy < 3'd2);
            if (pop && (out_rem == {{ADDR_W{1'b0}}, 1'b1}))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         issue_rem <= '0;
         out_rem   <= '0;
         pending   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= issue;
         if (load) begin
            rd_ptr    <= base_addr;
            issue_rem <= len;
            out_rem   <= len;
         end else begin
            if (issue) begin
               rd_ptr    <= rd_ptr + 1'b1;
               issue_rem <= issue_rem - 1'b1;
            end
            if (pop)
               out_rem <= out_rem - 1'b1;
         end
      end
   end

   // Two-entry FIFO whose head register is m_data itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data     <= '0;
         fifo_tail  <= '0;
         fifo_count <= 2'd0;
      end else begin
         case ({pending, pop})
            2'b10: begin
               if (fifo_count == 2'd0)
                  m_data <= bram_dout;
               else
                  fifo_tail <= bram_dout;
               fifo_count <= fifo_count + 2'd1;
            end
            2'b01: begin
               m_data     <= fifo_tail;
               fifo_count <= fifo_count - 2'd1;
            end
            2'b11: begin
               if (fifo_count == 2'd1) begin
                  m_data <= bram_dout;
               end else begin
                  m_data    <= fifo_tail;
                  fifo_tail <= bram_dout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdp_bram_reader.sv
// Scoreboarded random bench for sdp_bram_reader with a behavioural 1024-word BRAM
// and a reference model that simply lists the words each command should produce.
module tb_sdp_bram_reader;

   localparam int DATA_W = 75;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   len;
   logic              busy, done;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_dout;
   logic [DATA_W-1:0] m_data;
   logic              m_valid, m_ready, m_last;

   logic [DATA_W-1:0] ram [DEPTH];
   logic [DATA_W-1:0] exp_data[$];
   logic              exp_last[$];

   int total = 0;
   int bad   = 0;
   int ready_mode = 0;
   int ready_step = 0;

   sdp_bram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .bram_addr(bram_addr), .bram_dout(bram_dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bram_dout <= ram[bram_addr];

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // m_ready pattern: mode 0 always ready, mode 1 fixed 1,0,0,1,0,1 cycle, mode 2 random.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready_step++;
         case (ready_mode)
            1:       m_ready = (ready_step % 6 == 0) || (ready_step % 6 == 3) || (ready_step % 6 == 5);
            2:       m_ready = ($urandom_range(0, 1) == 1);
            default: m_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compares every accepted beat against the scoreboard and checks stall stability.
   logic              prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid && prev_valid && !prev_ready) begin
            checkOutput("stallData", 96'(m_data), 96'(prev_data));
            checkOutput("stallLast", 96'(m_last), 96'(prev_last));
         end
         if (m_valid && m_ready) begin
            if (exp_data.size() == 0) begin
               checkOutput("extraBeat", 96'(1), 96'(0));
            end else begin
               checkOutput("beatData", 96'(m_data), 96'(exp_data.pop_front()));
               checkOutput("beatLast", 96'(m_last), 96'(exp_last.pop_front()));
            end
         end
         prev_valid = m_valid;
         prev_ready = m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic applyStimulus(input int b, input int n, input int mode, input bit mid_start);
      int cycle, first_valid, limit;
      bit seen_done;
      ready_mode = mode;
      for (int i = 0; i < n; i++) begin
         exp_data.push_back(ram[(b + i) % DEPTH]);
         exp_last.push_back(i == n - 1);
      end
      @(negedge clk);
      start     = 1'b1;
      base_addr = ADDR_W'(b);
      len       = (ADDR_W + 1)'(n);
      cycle = 0; first_valid = 0; seen_done = 1'b0;
      limit = n * 8 + 20;
      while (!seen_done && cycle < limit) begin
         @(negedge clk);
         cycle++;
         start = 1'b0;
         if (mid_start && cycle == 500) begin
            start     = 1'b1;
            base_addr = ADDR_W'(5);
            len       = (ADDR_W + 1)'(3);
         end
         if (cycle == 1)
            checkOutput("busyAfterStart", 96'(busy), 96'(1));
         if (m_valid && first_valid == 0)
            first_valid = cycle;
         if (mode == 0 && n >= 4 && cycle <= 4)
            checkOutput("bramAddr", 96'(bram_addr), 96'((b + cycle - 1) % DEPTH));
         if (done)
            seen_done = 1'b1;
      end
      checkOutput("doneSeen", 96'(seen_done), 96'(1));
      if (mode == 0) begin
         checkOutput("doneCycle", 96'(cycle), 96'((n == 0) ? 1 : n + 3));
         if (n > 0)
            checkOutput("firstValid", 96'(first_valid), 96'(3));
      end
      if (n == 0)
         checkOutput("noValidLen0", 96'(first_valid), 96'(0));
      checkOutput("scoreboardEmpty", 96'(exp_data.size()), 96'(0));
      @(negedge clk);
      checkOutput("donePulseWidth", 96'(done), 96'(0));
      checkOutput("busyIdle", 96'(busy), 96'(0));
      exp_data.delete();
      exp_last.delete();
   endtask

   initial begin
      bit abort_done;
      for (int i = 0; i < DEPTH; i++)
         ram[i] = {$urandom(), $urandom(), $urandom()};
      rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
      #23;
      checkOutput("rstValid", 96'(m_valid), 96'(0));
      checkOutput("rstBusy", 96'(busy), 96'(0));
      checkOutput("rstDone", 96'(done), 96'(0));
      checkOutput("rstAddr", 96'(bram_addr), 96'(0));
      checkOutput("rstData", 96'(m_data), 96'(0));
      checkOutput("rstLast", 96'(m_last), 96'(0));
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8, 4, 0, 1'b0);
      applyStimulus(8, 4, 1, 1'b0);
      applyStimulus(1022, 4, 0, 1'b0);
      applyStimulus(0, 0, 0, 1'b0);
      applyStimulus(0, 1024, 0, 1'b1);
      for (int k = 0; k < 6; k++)
         applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 2, 1'b0);
      applyStimulus(1000, 30, 1, 1'b0);

      // Abort after two accepted words, then confirm a fresh command runs cleanly.
      ready_mode = 0;
      for (int i = 0; i < 10; i++) begin
         exp_data.push_back(ram[100 + i]);
         exp_last.push_back(i == 9);
      end
      @(negedge clk);
      start = 1'b1; base_addr = ADDR_W'(100); len = (ADDR_W + 1)'(10);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("abortRemaining", 96'(exp_data.size()), 96'(8));
      exp_data.delete();
      exp_last.delete();
      #1;
      checkOutput("abortValid", 96'(m_valid), 96'(0));
      checkOutput("abortBusy", 96'(busy), 96'(0));
      checkOutput("abortAddr", 96'(bram_addr), 96'(0));
      abort_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) abort_done = 1'b1;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) abort_done = 1'b1;
      end
      checkOutput("abortNoDone", 96'(abort_done), 96'(0));
      applyStimulus(300, 6, 0, 1'b0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdp_bram_reader.md
Name: sdp_bram_reader

Overview:
- Read-side engine for the 1024 x 75 simple-dual-port BRAM: on a start command it walks a contiguous address range on the BRAM read port.
- It absorbs the BRAM's one-cycle registered-address read latency and emits the words as a valid/ready stream with a last flag.
- It sits between a BRAM instance (read port) and downstream compute logic that consumes stored ciphertext/key words; the writer drives the BRAM's other port independently.

Parameters:
- DATA_W, 75, BRAM word width
- ADDR_W, 10, BRAM address width; depth = 2^ADDR_W

Ports:
- clk  in  1  single clock; also drives the BRAM read-port clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first address to read; sampled with start
- len  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last word is accepted, or after a len=0 command
- bram_addr  out  ADDR_W  to BRAM read address; registered
- bram_dout  in  DATA_W  from BRAM read data; equals ram[addr sampled at previous edge]
- m_data  out  DATA_W  output word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_last  out  1  qualifies the final word of the command

Behaviour:
- Reset (async, asynchronous assert): state=IDLE; busy=0, done=0, bram_addr=0, m_valid=0, m_last=0, m_data=0; FIFO emptied; pending=0; counters=0. An abort mid-command discards in-flight and buffered words; no done is produced.
- State machine:
  - IDLE: start=1 with len>0 loads rd_ptr=base_addr, issue_rem=len, out_rem=len; go to RUN.
  - IDLE: start=1 with len=0 goes to DONE.
  - RUN: issues reads and drains output; when out_rem reaches 0 at an accepted beat, go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- start while busy (RUN/DONE) is ignored and has no side effects.
- bram_addr = rd_ptr, registered.
- Read issue:
  - A read is issued in a RUN cycle when issue_rem>0 and (fifo_count + pending − pop) < 2, where pop = m_valid & m_ready.
  - On issue: rd_ptr <= rd_ptr+1 (mod 2^ADDR_W, wraps 1023→0), issue_rem decrements, pending <= 1. Otherwise pending <= 0.
- Capture: if pending=1, bram_dout is written into the 2-entry output FIFO at that edge. Capture is never blocked; issue gating guarantees space.
- Output:
  - m_data/m_valid present the FIFO head, with registered output.
  - m_last=1 when the head word is the final word of the command (out_rem==1).
  - m_data is held stable while m_valid=1 and m_ready=0.
  - m_valid never drops without acceptance.
- Latency: start sampled at edge E0 → bram_addr=base during cycle after E0 → first m_valid=1 after edge E2.
- Throughput: with m_ready held at 1, one word per cycle sustained.
- Simultaneous capture and pop on the same edge: FIFO count unchanged and order preserved.
- busy=1 in RUN and DONE.
- The reader never writes the BRAM. Coherency with concurrent writes to the same addresses is the user's responsibility.

Test Plan:
- Preload ram[8..11]=A0..A3; start base=8 len=4, m_ready=1 → m_valid first high after E2; A0,A1,A2,A3 on consecutive cycles; m_last only with A3; done one cycle after the A3 beat.
- Same range with m_ready toggling 1,0,0,1,0,1,... → every word delivered exactly once, in order; m_data stable while stalled; FIFO never overflows (no lost or duplicated words).
- base=1022 len=4 → bram_addr sequence 1022,1023,0,1; data ram[1022],ram[1023],ram[0],ram[1].
- len=0 → no m_valid; done pulses one cycle after start; busy=1 only in that cycle.
- len=1024 base=0, m_ready=1 → 1024 words in 1024 consecutive cycles; m_last on word 1023; a start pulse mid-run is ignored.
- Assert rst after 2 words accepted → m_valid, busy, bram_addr go to 0 immediately; no done; a new command afterwards runs cleanly from its own base.
